updown_counter: RTL
===================

UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter N, default 4, counter width in bits (1..32).
REQ-002 SHALL have parameter MOD, default 2**N, count modulus; legal range 2..2**N; maximum count value is MOD-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; one step per enabled cycle.
REQ-006 SHALL have port load  input  1  synchronous parallel load of d.
REQ-007 SHALL have port dir  input  1  direction (1 = up, 0 = down).
REQ-008 SHALL have port sat  input  1  boundary mode (1 = saturate, 0 = wrap modulo MOD).
REQ-009 SHALL have port d  input  N  load value.
REQ-010 SHALL have port q  output  N  registered count value.
REQ-011 SHALL have port tc  output  1  combinational terminal count: at boundary in the current direction.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse: a wrap occurred on the previous edge.

Function
REQ-013 Per-edge priority SHALL be reset > load > en > hold.
REQ-014 load=1 SHALL set q <= d if d <= MOD-1, else q <= MOD-1 (clamp); wrap <= 0; en and dir are ignored that cycle.
REQ-015 en=1, dir=1, q < MOD-1 SHALL give q <= q+1.
REQ-016 en=1, dir=0, q > 0 SHALL give q <= q-1.
REQ-017 en=1, dir=1, q == MOD-1 SHALL give q <= 0 and wrap <= 1 if sat=0, and q held with wrap <= 0 if sat=1.
REQ-018 en=1, dir=0, q == 0 SHALL give q <= MOD-1 and wrap <= 1 if sat=0, and q held with wrap <= 0 if sat=1.
REQ-019 en=0 and load=0 SHALL hold q and drive wrap <= 0.
REQ-020 tc SHALL equal (dir && q == MOD-1) || (!dir && q == 0), independent of en and sat; zero-latency from dir and q.
REQ-021 All arithmetic SHALL be at N+1 bits internally; no comparison SHALL truncate when MOD == 2**N.
REQ-022 A dir change SHALL take effect on the same edge it is sampled; no turnaround cycle.
REQ-023 q SHALL never hold a value >= MOD after any edge.

Reset
REQ-024 reset=1 at a rising edge SHALL set q <= 0 and wrap <= 0, overriding load and en.
REQ-025 Assertion of reset during counting SHALL abort the step in progress; the first post-reset step starts from 0.
REQ-026 Before the first reset q is undefined; tc SHALL be valid once q is defined.

Structure
REQ-027 Direction and mode encodings (DIR_UP/DIR_DOWN, MODE_WRAP/MODE_SAT) and the default width SHALL be `define constants in the shared defs.v.
REQ-028 Boundary detection (q == 0, q == MOD-1, tc) SHALL be one sub-module, counter_bound, parameterised by N and MOD; the main module holds all state.
REQ-029 The design SHALL be a single clk domain with no latches and no asynchronous paths.

Verification
REQ-030 N=4, MOD=10, sat=0, dir=1, en=1 from reset for 12 cycles -> q = 0..9,0,1; wrap high exactly the cycle after q==9; tc high while q==9.
REQ-031 N=4, MOD=10, dir=0, sat=0, load d=2 then en for 4 cycles -> q = 2,1,0,9,8; wrap pulses once after q 0->9.
REQ-032 N=4, MOD=16, sat=1, load d=14, dir=1, en for 4 cycles -> q = 14,15,15,15; wrap never asserted; tc=1 from q==15.
REQ-033 MOD=10, load d=13 -> q=9 (clamped); simultaneous load d=5 and en=1 -> q=5, not 6.
REQ-034 Mid-count at q=7, assert reset together with load=1, d=3 -> q=0, wrap=0; next en cycle, dir=1 -> q=1.
REQ-035 Toggle dir every cycle with en=1 from q=5, MOD=10 -> q alternates 6,5,6,5; en=0 for 3 cycles -> q holds, wrap=0.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg -- shared encodings for the up/down counter slice.
// Holds the direction/mode encodings and default width as global defines,
// plus the package-level typed constants and the per-edge operation enum.
`ifndef UPDOWN_COUNTER_DEFS
`define UPDOWN_COUNTER_DEFS
`define DIR_UP     1'b1
`define DIR_DOWN   1'b0
`define MODE_WRAP  1'b0
`define MODE_SAT   1'b1
`define DEFAULT_N  4
`endif

package updown_counter_pkg;

  localparam logic dir_up_c    = `DIR_UP;
  localparam logic dir_down_c  = `DIR_DOWN;
  localparam logic mode_wrap_c = `MODE_WRAP;
  localparam logic mode_sat_c  = `MODE_SAT;

  // What the counter does on an edge when reset is not asserted.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } op_e;

endpackage

// File: rtl/updown_counter_bound.sv
// counter_bound -- boundary detection for the up/down counter.
// Ports:
//   q       in  N  current count
//   dir     in  1  count direction (1 = up, 0 = down)
//   at_zero out 1  q == 0
//   at_max  out 1  q == MOD-1
//   tc      out 1  at the boundary in the current direction (combinational)
module counter_bound
  import updown_counter_pkg::*;
#(
  parameter int     N   = `DEFAULT_N,
  parameter longint MOD = 64'd1 << N
) (
  input  logic [N-1:0] q,
  input  logic         dir,
  output logic         at_zero,
  output logic         at_max,
  output logic         tc
);

  // Compare at N+1 bits so MOD == 2**N does not wrap MOD-1 into the sign bit.
  localparam logic [63:0] max64_c   = MOD - 64'd1;
  localparam logic [N:0]  max_val_c = max64_c[N:0];

  logic [N:0] q_ext_s;

  assign q_ext_s = {1'b0, q};

  // Boundary flags and terminal count, purely combinational from q and dir.
  always_comb begin
    at_zero = (q_ext_s == {(N+1){1'b0}});
    at_max  = (q_ext_s == max_val_c);
    if (dir == dir_up_c) begin
      tc = at_max;
    end else if (dir == dir_down_c) begin
      tc = at_zero;
    end else begin
      tc = 1'b0;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// updown_counter -- modulo-MOD up/down counter with load, saturate and wrap pulse.
// Ports:
//   clk   in  1  clock, all state on rising edge
//   reset in  1  synchronous active-high reset (q=0, wrap=0)
//   en    in  1  count enable
//   load  in  1  parallel load of d (clamped to MOD-1), beats en
//   dir   in  1  1 = up, 0 = down
//   sat   in  1  1 = saturate at boundary, 0 = wrap modulo MOD
//   d     in  N  load value
//   q     out N  registered count
//   tc    out 1  combinational terminal count for current dir
//   wrap  out 1  registered pulse: a wrap happened on the previous edge
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int     N   = `DEFAULT_N,
  parameter longint MOD = 64'd1 << N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic         dir,
  input  logic         sat,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap
);

  localparam logic [63:0] max64_c   = MOD - 64'd1;
  localparam logic [N:0]  max_val_c = max64_c[N:0];

  logic [N-1:0] q_r;
  logic         wrap_r;
  logic [N:0]   q_ext_s;
  logic [N:0]   d_ext_s;
  logic [N:0]   q_nxt_s;
  logic         wrap_nxt_s;
  logic         at_zero_s;
  logic         at_max_s;
  op_e          op_s;

  assign q_ext_s = {1'b0, q_r};
  assign d_ext_s = {1'b0, d};

  counter_bound #(
    .N   (N),
    .MOD (MOD)
  ) u_bound (
    .q       (q_r),
    .dir     (dir),
    .at_zero (at_zero_s),
    .at_max  (at_max_s),
    .tc      (tc)
  );

  // Select the edge operation: load beats count, count beats hold.
  always_comb begin
    op_s = OP_HOLD;
    if (load) begin
      op_s = OP_LOAD;
    end else if (en) begin
      op_s = OP_COUNT;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next count and wrap flag, all arithmetic at N+1 bits.
  always_comb begin
    q_nxt_s    = q_ext_s;
    wrap_nxt_s = 1'b0;
    case (op_s)
      OP_LOAD: begin
        if (d_ext_s > max_val_c) begin
          q_nxt_s = max_val_c;
        end else begin
          q_nxt_s = d_ext_s;
        end
      end
      OP_COUNT: begin
        if (dir == dir_up_c) begin
          if (at_max_s) begin
            if (sat == mode_wrap_c) begin
              q_nxt_s    = {(N+1){1'b0}};
              wrap_nxt_s = 1'b1;
            end else begin
              q_nxt_s = q_ext_s;
            end
          end else begin
            q_nxt_s = q_ext_s + {{N{1'b0}}, 1'b1};
          end
        end else begin
          if (at_zero_s) begin
            if (sat == mode_wrap_c) begin
              q_nxt_s    = max_val_c;
              wrap_nxt_s = 1'b1;
            end else begin
              q_nxt_s = q_ext_s;
            end
          end else begin
            q_nxt_s = q_ext_s - {{N{1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        q_nxt_s    = q_ext_s;
        wrap_nxt_s = 1'b0;
      end
    endcase
  end

  // Count and wrap registers; the final clamp keeps q below MOD even if
  // q started out of range before the first reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= {N{1'b0}};
      wrap_r <= 1'b0;
    end else begin
      q_r    <= (q_nxt_s > max_val_c) ? max_val_c[N-1:0] : q_nxt_s[N-1:0];
      wrap_r <= wrap_nxt_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;

endmodule
